// File: rtl/cmplx_mac_arbiter_if.sv
// cmplx_mac_arbiter_if: request/grant, operand and result bundle between the
// filter sequencers (master side) and the shared complex MAC arbiter (slave).
// Requester i owns bits [i*DATA_SIZE +: DATA_SIZE] of each operand bus.
interface cmplx_mac_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_SIZE = 32
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           op_valid;
    logic [NUM_REQ*DATA_SIZE-1:0] a_real;
    logic [NUM_REQ*DATA_SIZE-1:0] a_imag;
    logic [NUM_REQ*DATA_SIZE-1:0] c_real;
    logic [NUM_REQ*DATA_SIZE-1:0] c_imag;
    logic [NUM_REQ-1:0]           res_valid;
    logic [DATA_SIZE-1:0]         res_real;
    logic [DATA_SIZE-1:0]         res_imag;

    modport master (
        output req, op_valid, a_real, a_imag, c_real, c_imag,
        input  gnt, res_valid, res_real, res_imag
    );

    modport slave (
        input  req, op_valid, a_real, a_imag, c_real, c_imag,
        output gnt, res_valid, res_real, res_imag
    );
endinterface

// File: rtl/cmplx_mac_arbiter.sv
// cmplx_mac_arbiter: round-robin sharing of one pipelined complex MAC between
// NUM_REQ burst requesters. A granted requester streams NUM_TAPS operand
// beats; one accumulated complex result is returned per burst.
// Build option: define MAC_SATURATE_EN for saturating accumulators with a
// sticky saturation flag; otherwise accumulators wrap (two's complement).
module cmplx_mac_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int NUM_TAPS    = 20,
    parameter int DATA_SIZE   = 32,
    parameter int DATA_SIZE_2 = 64,
    parameter int BITS        = 10
) (
    input  logic               clock,
    input  logic               reset,
    cmplx_mac_arbiter_if.slave bus
);

    localparam int RW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW     = $clog2(NUM_TAPS + 1);
    localparam int STAGES = 1;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_e;

    // sign-extend a DATA_SIZE value into the product width
    function automatic logic signed [DATA_SIZE_2-1:0] sext(input logic signed [DATA_SIZE-1:0] v);
        return {{(DATA_SIZE_2-DATA_SIZE){v[DATA_SIZE-1]}}, v};
    endfunction

    // control state
    state_e                state_q;
    logic [RW-1:0]         rr_q;
    logic [RW-1:0]         sel_q;
    logic [CW-1:0]         cnt_q;
    logic                  drain_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    res_valid_q;
    logic [DATA_SIZE-1:0]  res_real_q;
    logic [DATA_SIZE-1:0]  res_imag_q;

    // arbitration result
    logic                  found_d;
    logic [RW-1:0]         sel_d;

    // datapath
    logic                          beat_acc;
    logic [STAGES:0]               vld_pipe;
    logic signed [DATA_SIZE-1:0]   ar_q, ai_q, cr_q, ci_q;
    logic signed [DATA_SIZE_2-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [DATA_SIZE_2-1:0] sum_re, sum_im, dq_re, dq_im;
    logic signed [DATA_SIZE-1:0]   acc_re_q, acc_im_q, acc_re_d, acc_im_d;

    assign beat_acc = (state_q == BURST) && ((gnt_q & bus.op_valid) != '0);

    // first requester at or above the rr pointer, wrapping around
    always_comb begin
        logic [RW:0] idx;
        found_d = 1'b0;
        sel_d   = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_q} + (RW+1)'(k);
            if (idx >= (RW+1)'(NUM_REQ))
                idx = idx - (RW+1)'(NUM_REQ);
            if (!found_d && bus.req[idx[RW-1:0]]) begin
                found_d = 1'b1;
                sel_d   = idx[RW-1:0];
            end
        end
    end

    // burst sequencing: grant, beat count, drain, result hand-off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            gnt_q       <= '0;
            res_valid_q <= '0;
            res_real_q  <= '0;
            res_imag_q  <= '0;
        end else begin
            res_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        sel_q   <= sel_d;
                        gnt_q   <= NUM_REQ'(1) << sel_d;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    // req[sel] may drop; only the beat count ends the burst
                    if (beat_acc) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(NUM_TAPS - 1)) begin
                            gnt_q   <= '0;
                            drain_q <= 1'b0;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // two cycles: operand regs -> products -> accumulators
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        res_valid_q <= NUM_REQ'(1) << sel_q;
                        res_real_q  <= acc_re_d;
                        res_imag_q  <= acc_im_d;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    cnt_q   <= '0;
                    rr_q    <= (int'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // operand capture from the granted requester plus beat valid pipeline
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            ar_q     <= '0;
            ai_q     <= '0;
            cr_q     <= '0;
            ci_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], beat_acc};
            if (beat_acc) begin
                ar_q <= bus.a_real[sel_q*DATA_SIZE +: DATA_SIZE];
                ai_q <= bus.a_imag[sel_q*DATA_SIZE +: DATA_SIZE];
                cr_q <= bus.c_real[sel_q*DATA_SIZE +: DATA_SIZE];
                ci_q <= bus.c_imag[sel_q*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // stage 1: the four partial products at full width
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else if (vld_pipe[0]) begin
            p_rr_q <= sext(ar_q) * sext(cr_q);
            p_ii_q <= sext(ai_q) * sext(ci_q);
            p_ri_q <= sext(ar_q) * sext(ci_q);
            p_ir_q <= sext(ai_q) * sext(cr_q);
        end
    end

    // complex combine and dequantize (arithmetic shift keeps the sign)
    assign sum_re = p_rr_q - p_ii_q;
    assign sum_im = p_ri_q + p_ir_q;
    assign dq_re  = sum_re >>> BITS;
    assign dq_im  = sum_im >>> BITS;

`ifdef MAC_SATURATE_EN
    localparam logic signed [DATA_SIZE_2-1:0] SAT_MAX =
        {{(DATA_SIZE_2-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [DATA_SIZE_2-1:0] SAT_MIN =
        {{(DATA_SIZE_2-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic signed [DATA_SIZE_2-1:0] wide_re, wide_im;
    logic                          sat_hit;
    logic                          sat_flag_q;

    // stage 2: add at full width, then clamp each component
    always_comb begin
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        sat_hit  = 1'b0;
        wide_re  = sext(acc_re_q) + dq_re;
        wide_im  = sext(acc_im_q) + dq_im;
        if (vld_pipe[STAGES]) begin
            if (wide_re > SAT_MAX) begin
                acc_re_d = SAT_MAX[DATA_SIZE-1:0];
                sat_hit  = 1'b1;
            end else if (wide_re < SAT_MIN) begin
                acc_re_d = SAT_MIN[DATA_SIZE-1:0];
                sat_hit  = 1'b1;
            end else begin
                acc_re_d = wide_re[DATA_SIZE-1:0];
            end
            if (wide_im > SAT_MAX) begin
                acc_im_d = SAT_MAX[DATA_SIZE-1:0];
                sat_hit  = 1'b1;
            end else if (wide_im < SAT_MIN) begin
                acc_im_d = SAT_MIN[DATA_SIZE-1:0];
                sat_hit  = 1'b1;
            end else begin
                acc_im_d = wide_im[DATA_SIZE-1:0];
            end
        end
    end

    // sticky saturation indicator for the current burst
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sat_flag_q <= 1'b0;
        else if (state_q == DONE)
            sat_flag_q <= 1'b0;
        else
            sat_flag_q <= sat_flag_q | sat_hit;
    end
`else
    // upper dequantized bits only matter when saturating
    logic unused_dq_hi;
    assign unused_dq_hi = ^{dq_re[DATA_SIZE_2-1:DATA_SIZE], dq_im[DATA_SIZE_2-1:DATA_SIZE]};

    // stage 2: wrapping accumulate
    always_comb begin
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        if (vld_pipe[STAGES]) begin
            acc_re_d = acc_re_q + dq_re[DATA_SIZE-1:0];
            acc_im_d = acc_im_q + dq_im[DATA_SIZE-1:0];
        end
    end
`endif

    // accumulators, cleared once the result has been handed off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else if (state_q == DONE) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_real  = res_real_q;
    assign bus.res_imag  = res_imag_q;

endmodule

// File: tb/tb_cmplx_mac_arbiter.sv
// tb_cmplx_mac_arbiter: requester agents feed bursts, a reference model
// computes each burst's complex sum when the job is queued, and a monitor
// pops and compares results, owners, latency and grant spacing.
module tb_cmplx_mac_arbiter;
    localparam int NR = 2, NT = 4, DS = 32, BITS = 10;
    localparam logic signed [31:0] Q    = 32'sd1024;
    localparam logic signed [31:0] MAXP = 32'sh7fffffff;

    typedef struct {
        logic signed [31:0] ar, ai, cr, ci;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cmplx_mac_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(DS)) bus();

    cmplx_mac_arbiter #(
        .NUM_REQ(NR), .NUM_TAPS(NT), .DATA_SIZE(DS), .DATA_SIZE_2(64), .BITS(BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    beat_t              beats [NR][$];
    logic signed [31:0] exp_re[NR][$];
    logic signed [31:0] exp_im[NR][$];
    int                 gnt_order[$];
    int                 sent[NR];
    int                 stall[NR];
    bit                 drop_early[NR];
    int                 last_beat_cyc[NR];
    bit                 gaps = 0;
    bit                 noise_all = 0;

    // ---------------- reference model ----------------
    function automatic logic signed [31:0] acc_step(input logic signed [31:0] acc, input longint d);
        longint s;
        s = longint'(acc) + d;
`ifdef MAC_SATURATE_EN
        if (s > 64'sd2147483647)  return MAXP;
        if (s < -64'sd2147483648) return 32'sh80000000;
        return s[31:0];
`else
        return s[31:0];
`endif
    endfunction

    task automatic add_job(input int id, input beat_t jb[NT]);
        logic signed [31:0] re, im;
        longint dr, di;
        re = 0;
        im = 0;
        for (int k = 0; k < NT; k++) begin
            dr = (longint'(jb[k].ar) * longint'(jb[k].cr) - longint'(jb[k].ai) * longint'(jb[k].ci)) >>> BITS;
            di = (longint'(jb[k].ar) * longint'(jb[k].ci) + longint'(jb[k].ai) * longint'(jb[k].cr)) >>> BITS;
            re = acc_step(re, dr);
            im = acc_step(im, di);
            beats[id].push_back(jb[k]);
        end
        exp_re[id].push_back(re);
        exp_im[id].push_back(im);
    endtask

    task automatic add_const(input int id, input logic signed [31:0] ar, ai, cr, ci);
        beat_t jb[NT];
        for (int k = 0; k < NT; k++) begin
            jb[k].ar = ar; jb[k].ai = ai; jb[k].cr = cr; jb[k].ci = ci;
        end
        add_job(id, jb);
    endtask

    function automatic logic signed [31:0] rnd();
        int v;
        v = int'($urandom_range(0, 2097152)) - 1048576;
        return v;
    endfunction

    task automatic add_rand(input int id);
        beat_t jb[NT];
        for (int k = 0; k < NT; k++) begin
            jb[k].ar = rnd(); jb[k].ai = rnd(); jb[k].cr = rnd(); jb[k].ci = rnd();
        end
        add_job(id, jb);
    endtask

    // ---------------- requester agents (one step per negedge) ----------------
    task automatic agent_step();
        for (int i = 0; i < NR; i++) begin
            bit    has;
            beat_t b;
            has = beats[i].size() > 0;
            bus.req[i]      = has && !(drop_early[i] && sent[i] > 0);
            bus.op_valid[i] = 1'b0;
            if (has && bus.gnt[i]) begin
                if (stall[i] > 0) begin
                    stall[i]--;
                end else if (!(gaps && $urandom_range(0, 3) == 0)) begin
                    b = beats[i].pop_front();
                    bus.op_valid[i]          = 1'b1;
                    bus.a_real[i*DS +: DS]   = b.ar;
                    bus.a_imag[i*DS +: DS]   = b.ai;
                    bus.c_real[i*DS +: DS]   = b.cr;
                    bus.c_imag[i*DS +: DS]   = b.ci;
                    sent[i]++;
                    if (sent[i] == NT) begin
                        sent[i]          = 0;
                        last_beat_cyc[i] = cyc;
                    end
                end
            end else if (noise_all || $urandom_range(0, 1) == 1) begin
                // ungranted beats must be ignored by the arbiter
                bus.op_valid[i]        = 1'b1;
                bus.a_real[i*DS +: DS] = $urandom;
                bus.a_imag[i*DS +: DS] = $urandom;
                bus.c_real[i*DS +: DS] = $urandom;
                bus.c_imag[i*DS +: DS] = $urandom;
            end
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < NR; i++)
            if (beats[i].size() > 0 || exp_re[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run(input string name, input int max_cyc);
        int n;
        n = 0;
        while (busy() && n < max_cyc) begin
            @(negedge clock);
            agent_step();
            n++;
        end
        total++;
        if (busy()) begin
            bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required done", name, n);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [NR-1:0]      prev_gnt = '0;
    int                 owner = -1;
    int                 last_res = -100;
    int                 rid;
    logic signed [31:0] er, ei;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                total++;
                if (bus.gnt !== '0 || bus.res_valid !== '0 || bus.res_real !== '0 || bus.res_imag !== '0) begin
                    bad++;
                    $display("FAIL reset_outputs: gnt=%b res_valid=%b re=%0d im=%0d, required all 0",
                             bus.gnt, bus.res_valid, bus.res_real, bus.res_imag);
                end
                prev_gnt = '0;
                owner    = -1;
                last_res = -100;
            end else begin
                if (bus.gnt != '0 && prev_gnt == '0) begin
                    total++;
                    if (!$onehot(bus.gnt) || cyc - last_res < 2) begin
                        bad++;
                        $display("FAIL grant_rise: gnt=%b at cyc %0d last res cyc %0d, required one-hot and >=2 after",
                                 bus.gnt, cyc, last_res);
                    end
                    for (int i = 0; i < NR; i++) if (bus.gnt[i]) owner = i;
                    gnt_order.push_back(owner);
                end
                if (bus.res_valid != '0) begin
                    rid = 0;
                    for (int i = NR - 1; i >= 0; i--) if (bus.res_valid[i]) rid = i;
                    total++;
                    if (!$onehot(bus.res_valid) || rid != owner || bus.gnt != '0) begin
                        bad++;
                        $display("FAIL res_owner: res_valid=%b gnt=%b, required one-hot to owner %0d with no grant",
                                 bus.res_valid, bus.gnt, owner);
                    end
                    total++;
                    if (exp_re[rid].size() == 0) begin
                        bad++;
                        $display("FAIL res_unexpected: result for %0d with nothing queued", rid);
                    end else begin
                        er = exp_re[rid].pop_front();
                        ei = exp_im[rid].pop_front();
                        if ($signed(bus.res_real) != er || $signed(bus.res_imag) != ei) begin
                            bad++;
                            $display("FAIL res_value[%0d]: got (%0d,%0d), required (%0d,%0d)",
                                     rid, $signed(bus.res_real), $signed(bus.res_imag), er, ei);
                        end
                        total++;
                        if (cyc != last_beat_cyc[rid] + 3) begin
                            bad++;
                            $display("FAIL res_latency[%0d]: at cyc %0d, required %0d",
                                     rid, cyc, last_beat_cyc[rid] + 3);
                        end
                    end
                    last_res = cyc;
                end
                prev_gnt = bus.gnt;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bus.req = '0; bus.op_valid = '0;
        bus.a_real = '0; bus.a_imag = '0; bus.c_real = '0; bus.c_imag = '0;
        for (int i = 0; i < NR; i++) begin
            sent[i] = 0; stall[i] = 0; drop_early[i] = 0; last_beat_cyc[i] = -100;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // T1 / T2: directed products
        add_const(0, Q, 0, Q, 0);
        run("t1", 100);
        add_const(0, 0, Q, 0, Q);
        add_const(0, Q, Q, Q, 0);
        run("t2", 200);

        // T3: both requesting from reset release -> alternating grants
        @(negedge clock);
        reset = 1'b1;
        add_const(0, Q, 0, Q, 0);
        add_const(1, 0, Q, Q, 0);
        add_const(0, Q, Q, Q, Q);
        add_const(1, Q, 0, 0, Q);
        agent_step();
        gnt_order.delete();
        @(negedge clock);
        reset = 1'b0;
        run("t3", 300);
        total++;
        if (gnt_order.size() != 4) begin
            bad++;
            $display("FAIL t3_grant_count: %0d grants, required 4", gnt_order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (gnt_order[k] != k % 2) begin
                    bad++;
                    $display("FAIL t3_grant_order[%0d]: got %0d, required %0d", k, gnt_order[k], k % 2);
                end
            end
        end

        // T4: owner stalls 3 cycles while the other requester spams op_valid
        stall[0]  = 3;
        noise_all = 1;
        add_const(0, Q, 0, Q, 0);
        run("t4", 100);
        noise_all = 0;

        // T5: reset after beat 2, then a clean burst
        add_const(0, Q, 0, Q, 0);
        n = 0;
        while (sent[0] < 2 && n < 50) begin
            @(negedge clock);
            agent_step();
            n++;
        end
        total++;
        if (sent[0] < 2) begin
            bad++;
            $display("FAIL t5_progress: %0d beats sent, required 2", sent[0]);
        end
        @(posedge clock);
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        beats[0].delete();
        sent[0] = 0;
        if (exp_re[0].size() > 0) begin
            void'(exp_re[0].pop_back());
            void'(exp_im[0].pop_back());
        end
        bus.req = '0;
        bus.op_valid = '0;
        reset = 1'b0;
        add_const(0, Q, 0, Q, 0);
        run("t5", 100);

        // T6: near-full-scale real part, saturating or wrapping per build
        add_const(0, MAXP, 0, Q, 0);
        run("t6", 100);

        // random traffic with gaps, early req drop and back-to-back jobs
        gaps = 1;
        for (int j = 0; j < 16; j++) begin
            int id;
            id = int'($urandom_range(0, NR - 1));
            drop_early[id] = bit'($urandom_range(0, 1));
            add_rand(id);
            repeat ($urandom_range(0, 6)) begin
                @(negedge clock);
                agent_step();
            end
        end
        run("rand", 2000);

        repeat (4) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

endmodule
